// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII codes and the receive handshake state type.
package uart_pkg;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StWaitLow
  } hs_state_e;

endpackage

// File: rtl/uart_dec_acc.sv
// Decimal digit accumulator with digit-count limit and overflow detection.
module uart_dec_acc #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,     // accept i_digit
  input  logic [3:0]       i_digit,
  input  logic             i_bad,      // non-digit, non-LF byte seen
  input  logic             i_clear,    // end of line
  output logic [WIDTH-1:0] o_acc,
  output logic             o_err,
  output logic             o_nonempty
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic [WIDTH-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic             r_err;

  logic [WIDTH+3:0] w_next;
  logic             w_ovf;
  logic             w_full;

  // Four spare bits hold acc*10+9 without wrapping, so the range check is exact.
  assign w_next = ({4'b0000, r_acc} * (WIDTH + 4)'(10)) + (WIDTH + 4)'(i_digit);
  assign w_ovf  = (w_next > {4'b0000, {WIDTH{1'b1}}});
  assign w_full = (r_cnt == CntW'(MAX_DIGITS));

  // Accumulate digits; a rejected digit leaves acc untouched and latches the error.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_bad) begin
      r_err <= 1'b1;
    end else if (i_step) begin
      if (w_full || w_ovf) begin
        r_err <= 1'b1;
      end else begin
        r_acc <= w_next[WIDTH-1:0];
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_acc      = r_acc;
  assign o_err      = r_err;
  assign o_nonempty = (r_cnt != '0);

endmodule

// File: rtl/uart_rx_decimal.sv
// Pulls bytes from the UART receiver handshake and parses CR-terminated decimal lines.
module uart_rx_decimal
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_word,
  input  logic             in_RXNE,
  input  logic             in_Rx_ORE,
  output logic             out_RXNE_clear,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  output logic             out_err,
  output logic [7:0]       out_ore_cnt
);

  hs_state_e        r_state;
  hs_state_e        w_state_d;
  logic [7:0]       r_byte;
  logic [WIDTH-1:0] r_value;
  logic             r_valid;
  logic             r_err;
  logic             r_ore_prev;
  logic [7:0]       r_ore_cnt;

  logic             w_parse;
  logic             w_is_digit;
  logic [7:0]       w_sub;
  logic             w_step;
  logic             w_cr;
  logic             w_bad;
  logic [WIDTH-1:0] w_acc;
  logic             w_acc_err;
  logic             w_nonempty;

  // Parsing happens once per byte, at the end of the ACK cycle.
  assign w_parse    = (r_state == StAck);
  assign w_is_digit = (r_byte >= CH_0) && (r_byte <= CH_9);
  assign w_sub      = r_byte - CH_0;
  assign w_step     = w_parse && w_is_digit;
  assign w_cr       = w_parse && (r_byte == CH_CR);
  assign w_bad      = w_parse && !w_is_digit && (r_byte != CH_CR) && (r_byte != CH_LF);

  uart_dec_acc #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_step),
    .i_digit    (w_sub[3:0]),
    .i_bad      (w_bad),
    .i_clear    (w_cr),
    .o_acc      (w_acc),
    .o_err      (w_acc_err),
    .o_nonempty (w_nonempty)
  );

  // Handshake state register and byte capture in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && in_RXNE) r_byte <= in_word;
    end
  end

  // Next-state and acknowledge pulse; WAIT_LOW ensures one byte per RXNE assertion.
  always_comb begin
    w_state_d      = r_state;
    out_RXNE_clear = 1'b0;
    unique case (r_state)
      StIdle:    if (in_RXNE) w_state_d = StAck;
      StAck: begin
        out_RXNE_clear = 1'b1;
        w_state_d      = StWaitLow;
      end
      StWaitLow: if (!in_RXNE) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Line result: publish value or flag error when CR arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_cr) begin
        if (!w_acc_err && w_nonempty) begin
          r_value <= w_acc;
          r_valid <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Saturating count of overrun rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ore_prev <= 1'b0;
      r_ore_cnt  <= '0;
    end else begin
      r_ore_prev <= in_Rx_ORE;
      if (in_Rx_ORE && !r_ore_prev && r_ore_cnt != 8'hFF) r_ore_cnt <= r_ore_cnt + 8'd1;
    end
  end

  assign out_value   = r_value;
  assign out_valid   = r_valid;
  assign out_err     = r_err;
  assign out_ore_cnt = r_ore_cnt;

endmodule

// File: tb/tb_uart_rx_decimal.sv
// Self-checking bench for uart_rx_decimal: directed test plan plus random lines.
module tb_uart_rx_decimal;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_word;
  logic        in_RXNE;
  logic        in_Rx_ORE;
  logic        out_RXNE_clear;
  logic [15:0] out_value;
  logic        out_valid;
  logic        out_err;
  logic [7:0]  out_ore_cnt;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_errp = 0;
  int n_clr = 0;
  int n_both = 0;
  int exp_value = 0;

  always #5 clk = ~clk;

  uart_rx_decimal #(
    .WIDTH      (16),
    .MAX_DIGITS (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_word        (in_word),
    .in_RXNE        (in_RXNE),
    .in_Rx_ORE      (in_Rx_ORE),
    .out_RXNE_clear (out_RXNE_clear),
    .out_value      (out_value),
    .out_valid      (out_valid),
    .out_err        (out_err),
    .out_ore_cnt    (out_ore_cnt)
  );

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) n_valid++;
    if (out_err === 1'b1) n_errp++;
    if (out_RXNE_clear === 1'b1) n_clr++;
    if (out_valid === 1'b1 && out_err === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal line semantics on a whole byte list (CR not included).
  function automatic void ref_line(input byte unsigned q[$], output bit ok, output int val);
    int cnt = 0;
    bit e = 1'b0;
    int d;
    val = 0;
    foreach (q[i]) begin
      if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
        d = int'(q[i]) - 48;
        if (cnt == 5 || val * 10 + d > 65535) e = 1'b1;
        else begin
          val = val * 10 + d;
          cnt++;
        end
      end else if (q[i] != 8'h0A) begin
        e = 1'b1;
      end
    end
    ok = !e && (cnt > 0);
  endfunction

  // One byte through the handshake, RXNE held for 'hold' cycles; checks single ack.
  task automatic send_byte(input logic [7:0] b, input int hold);
    int c0;
    c0 = n_clr;
    @(negedge clk);
    in_word = b;
    in_RXNE = 1'b1;
    repeat (hold) @(negedge clk);
    in_RXNE = 1'b0;
    in_word = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("clear_per_byte", n_clr - c0, 1);
  endtask

  task automatic run_line(input string tag, input byte unsigned q[$], input int hold);
    int v0, e0, val;
    bit ok;
    v0 = n_valid;
    e0 = n_errp;
    foreach (q[i]) send_byte(q[i], hold);
    send_byte(8'h0D, hold);
    ref_line(q, ok, val);
    if (ok) exp_value = val;
    chk({tag, "_valid"}, n_valid - v0, ok ? 1 : 0);
    chk({tag, "_err"}, n_errp - e0, ok ? 0 : 1);
    chk({tag, "_value"}, int'(out_value), exp_value);
  endtask

  function automatic void to_q(input string s, output byte unsigned q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  initial begin
    byte unsigned q[$];
    int n, r;
    rst = 1'b1;
    in_word = '0;
    in_RXNE = 1'b0;
    in_Rx_ORE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_value", int'(out_value), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_clear", int'(out_RXNE_clear), 0);
    chk("rst_ore", int'(out_ore_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    to_q("123", q);   run_line("t1", q, 4);
    chk("t1_const", int'(out_value), 123);
    to_q("65535", q); run_line("t2a", q, 4);
    chk("t2a_const", int'(out_value), 65535);
    to_q("65536", q); run_line("t2b", q, 3);
    chk("t2b_hold", int'(out_value), 65535);
    to_q("1x2", q);   run_line("t3a", q, 2);
    to_q("\n7", q);   run_line("t3b", q, 2);
    chk("t3b_const", int'(out_value), 7);
    to_q("123456", q); run_line("t4a", q, 1);
    q = {};            run_line("t4b", q, 1);
    to_q("00042", q);  run_line("t4c", q, 1);
    chk("t4c_const", int'(out_value), 42);

    q = {8'h35};
    send_byte(8'h35, 20);
    send_byte(8'h0D, 2);
    chk("t5_value", int'(out_value), 5);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk); in_Rx_ORE = 1'b1;
      @(negedge clk); in_Rx_ORE = 1'b0;
    end
    @(negedge clk);
    chk("ore_10", int'(out_ore_cnt), 10);
    for (int i = 0; i < 290; i++) begin
      @(negedge clk); in_Rx_ORE = 1'b1;
      @(negedge clk); in_Rx_ORE = 1'b0;
    end
    @(negedge clk);
    chk("ore_sat", int'(out_ore_cnt), 255);

    send_byte(8'h39, 2);
    send_byte(8'h38, 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_value", int'(out_value), 0);
    chk("mid_rst_ore", int'(out_ore_cnt), 0);
    exp_value = 0;
    to_q("3", q); run_line("t6", q, 3);
    chk("t6_const", int'(out_value), 3);

    // Random lines: mostly digits, occasional junk or LF, random RXNE hold.
    for (int l = 0; l < 40; l++) begin
      q = {};
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0) q.push_back(8'h0A);
        else if (r == 1) q.push_back(8'($urandom_range(8'h3A, 8'h7E)));
        else q.push_back(8'($urandom_range(8'h30, 8'h39)));
      end
      run_line("rand", q, $urandom_range(1, 6));
    end

    chk("never_both", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_decimal.md
Name: uart_rx_decimal

Overview:
- Receive-side consumer for the UART core. It pulls bytes from the receiver's RXNE/word/RXNE_clear handshake and parses ASCII decimal lines ('0'..'9' terminated by CR) into an unsigned binary value.
- It complements the transmit path, which pushes ASCII digits out through the valid/BUSY handshake.
- It sits in the CPU-level wrapper between the UART core receiver outputs and user logic.
- It also counts receiver overrun events.

Parameters:
- WIDTH, 16: width of parsed value and accumulator.
- MAX_DIGITS, 5: maximum digits accepted per line; one more digit is an error.

Ports:
- clk  in  1  system clock, same domain as the UART core.
- rst  in  1  reset; synchronous and active-high. One clock; reset is synchronous and active-high.
- in_word  in  8  received byte from the UART receiver; valid while in_RXNE=1.
- in_RXNE  in  1  receiver-not-empty flag.
- in_Rx_ORE  in  1  receiver overrun flag (level).
- out_RXNE_clear  out  1  one-cycle pulse acknowledging the byte.
- out_value  out  WIDTH  last successfully parsed value; held until the next success.
- out_valid  out  1  one-cycle pulse when out_value is updated.
- out_err  out  1  one-cycle pulse when a line ends in error.
- out_ore_cnt  out  8  saturating count of in_Rx_ORE rising edges.

Behaviour:

Reset:
- All outputs are 0.
- Accumulator, digit count and error latch are 0.
- Handshake FSM is in IDLE.
- The ORE edge-detect register is 0.
- If reset is asserted mid-line, the partial line is discarded.

Handshake FSM (IDLE, ACK, WAIT_LOW):
- IDLE: if in_RXNE=1 in cycle N, register in_word into byte_q at the end of N and go to ACK.
- ACK (cycle N+1): out_RXNE_clear=1 for exactly this cycle. The parse step consumes byte_q at the end of N+1. Go to WAIT_LOW.
- WAIT_LOW: stay until in_RXNE=0, then go to IDLE. This guarantees one byte is consumed per RXNE assertion even if the core drops RXNE late.
- Throughput: one byte per at least 3 cycles. This is far faster than the UART byte time.

Parse step (once per byte, at the end of the ACK cycle):
- Digit 0x30..0x39, d = byte - 0x30:
  - If digit count = MAX_DIGITS, or acc*10+d > 2^WIDTH-1, set the error latch. acc is unchanged.
  - Otherwise acc <= acc*10+d and count <= count+1.
  - Compute with WIDTH+4 bits internally; compare before truncation.
- CR 0x0D, end of line:
  - If the error latch is clear and count > 0: out_value <= acc and out_valid=1 in cycle N+2.
  - Else (error, or empty line): out_err=1 in cycle N+2. out_value is unchanged.
  - In both cases acc, count and the error latch clear.
- LF 0x0A: ignored, no state change. This allows CR LF line endings.
- Any other byte: sets the error latch. The error is reported at the next CR.
- out_valid and out_err are never both asserted.

Overrun:
- A rising edge of in_Rx_ORE increments out_ore_cnt, saturating at 255.
- Parsing is unaffected.

Simultaneous events:
- An ORE edge in the same cycle as a parse step: both take effect.
- in_RXNE rising during ACK or WAIT_LOW is not sampled until IDLE.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants: CH_0=0x30, CH_9=0x39, CH_CR=0x0D, CH_LF=0x0A.
  - Handshake state enum (IDLE, ACK, WAIT_LOW).
- One natural sub-module, uart_dec_acc: the combinational/registered digit accumulator with overflow check. It is parameterised on WIDTH and MAX_DIGITS and exposes step, clear, acc, err.

Test Plan:
1. Bytes "1","2","3",CR, each with RXNE held 4 cycles and dropped after out_RXNE_clear -> out_valid pulse with out_value=123. Exactly one out_RXNE_clear per byte.
2. "65535",CR -> out_value=65535. Then "65536",CR -> out_err pulse; out_value stays 65535.
3. "1","x","2",CR,LF -> out_err pulse, no out_valid. Then "7",CR -> out_value=7.
4. "123456",CR (6 digits, MAX_DIGITS=5) -> out_err. A bare CR -> out_err. "00042",CR -> out_value=42.
5. RXNE held high for 20 cycles on one byte "5", then CR -> one clear pulse per byte, out_value=5 (no double-count).
6. Toggle in_Rx_ORE 300 times -> out_ore_cnt=255. Assert rst mid-line after "98", then "3",CR -> out_value=3, out_ore_cnt=0 after reset.
